// File: rtl/morse_char_decoder.sv
// Morse character decoder: collects DIT/DAH elements into a pattern, decodes ITU
// letters/digits/punctuation to ASCII and queues them in an output FIFO.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no element collected (len 0); SPACE may push a word space
// S_COLLECT | shifting elements into pat; GAP/SPACE decodes and pushes
// S_OVERRUN | more than MAX_ELEMS elements seen; waits for GAP/SPACE to push '*'
module morse_char_decoder #(
    parameter int MAX_ELEMS  = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] inputSignal,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_char,
    output logic       err,
    output logic       overflow
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] MAX_LEN  = 4'(MAX_ELEMS);
    localparam bit         PUNCT_EN = (MAX_ELEMS >= 6);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    localparam logic [2:0] SYM_DIT   = 3'd1;
    localparam logic [2:0] SYM_DAH   = 3'd2;
    localparam logic [2:0] SYM_GAP   = 3'd3;
    localparam logic [2:0] SYM_SPACE = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_OVERRUN} state_t;

    state_t      state, state_nxt;
    logic [3:0]  len, len_nxt;
    logic [7:0]  pat, pat_nxt;
    logic        space_pend, space_pend_nxt;
    logic [7:0]  last_char;
    logic        is_elem, elem_bit, is_end;
    logic        fsm_push, fsm_err;
    logic [7:0]  fsm_char;
    logic        push_req, push_err;
    logic [7:0]  push_char;
    logic [7:0]  dec_char;
    logic        dec_ok;

    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0]  mem [FIFO_DEPTH];
    logic        fifo_empty, fifo_full, pop, wr_en;

    assign is_elem  = (inputSignal == SYM_DIT) || (inputSignal == SYM_DAH);
    assign elem_bit = (inputSignal == SYM_DAH);
    assign is_end   = (inputSignal == SYM_GAP) || (inputSignal == SYM_SPACE);

    always_comb begin
        dec_char = 8'h2A;
        dec_ok   = 1'b1;
        case ({len, pat})
            {4'd1, 8'b0}:     dec_char = 8'h45;
            {4'd1, 8'b1}:     dec_char = 8'h54;
            {4'd2, 8'b00}:    dec_char = 8'h49;
            {4'd2, 8'b01}:    dec_char = 8'h41;
            {4'd2, 8'b10}:    dec_char = 8'h4E;
            {4'd2, 8'b11}:    dec_char = 8'h4D;
            {4'd3, 8'b000}:   dec_char = 8'h53;
            {4'd3, 8'b001}:   dec_char = 8'h55;
            {4'd3, 8'b010}:   dec_char = 8'h52;
            {4'd3, 8'b011}:   dec_char = 8'h57;
            {4'd3, 8'b100}:   dec_char = 8'h44;
            {4'd3, 8'b101}:   dec_char = 8'h4B;
            {4'd3, 8'b110}:   dec_char = 8'h47;
            {4'd3, 8'b111}:   dec_char = 8'h4F;
            {4'd4, 8'b0000}:  dec_char = 8'h48;
            {4'd4, 8'b0001}:  dec_char = 8'h56;
            {4'd4, 8'b0010}:  dec_char = 8'h46;
            {4'd4, 8'b0100}:  dec_char = 8'h4C;
            {4'd4, 8'b0110}:  dec_char = 8'h50;
            {4'd4, 8'b0111}:  dec_char = 8'h4A;
            {4'd4, 8'b1000}:  dec_char = 8'h42;
            {4'd4, 8'b1001}:  dec_char = 8'h58;
            {4'd4, 8'b1010}:  dec_char = 8'h43;
            {4'd4, 8'b1011}:  dec_char = 8'h59;
            {4'd4, 8'b1100}:  dec_char = 8'h5A;
            {4'd4, 8'b1101}:  dec_char = 8'h51;
            {4'd5, 8'b11111}: dec_char = 8'h30;
            {4'd5, 8'b01111}: dec_char = 8'h31;
            {4'd5, 8'b00111}: dec_char = 8'h32;
            {4'd5, 8'b00011}: dec_char = 8'h33;
            {4'd5, 8'b00001}: dec_char = 8'h34;
            {4'd5, 8'b00000}: dec_char = 8'h35;
            {4'd5, 8'b10000}: dec_char = 8'h36;
            {4'd5, 8'b11000}: dec_char = 8'h37;
            {4'd5, 8'b11100}: dec_char = 8'h38;
            {4'd5, 8'b11110}: dec_char = 8'h39;
            default:          dec_ok   = 1'b0;
        endcase
        if (PUNCT_EN && len == 4'd6) begin
            dec_ok = 1'b1;
            case (pat)
                8'b010101: dec_char = 8'h2E;
                8'b110011: dec_char = 8'h2C;
                8'b001100: dec_char = 8'h3F;
                default:   dec_ok   = 1'b0;
            endcase
        end
        if (!dec_ok) dec_char = 8'h2A;
    end

    always_comb begin
        state_nxt      = state;
        len_nxt        = len;
        pat_nxt        = pat;
        space_pend_nxt = 1'b0;
        fsm_push       = 1'b0;
        fsm_char       = dec_char;
        fsm_err        = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_elem) begin
                    state_nxt = S_COLLECT;
                    len_nxt   = 4'd1;
                    pat_nxt   = {7'b0, elem_bit};
                end else if (inputSignal == SYM_SPACE && last_char != 8'h20) begin
                    fsm_push = 1'b1;
                    fsm_char = 8'h20;
                end
            end
            S_COLLECT: begin
                if (is_elem) begin
                    if (len == MAX_LEN) begin
                        state_nxt = S_OVERRUN;
                    end else begin
                        len_nxt = len + 4'd1;
                        pat_nxt = {pat[6:0], elem_bit};
                    end
                end else if (is_end) begin
                    fsm_push       = 1'b1;
                    fsm_err        = !dec_ok;
                    state_nxt      = S_IDLE;
                    len_nxt        = 4'd0;
                    pat_nxt        = 8'd0;
                    space_pend_nxt = (inputSignal == SYM_SPACE);
                end
            end
            S_OVERRUN: begin
                if (is_end) begin
                    fsm_push       = 1'b1;
                    fsm_char       = 8'h2A;
                    fsm_err        = 1'b1;
                    state_nxt      = S_IDLE;
                    len_nxt        = 4'd0;
                    pat_nxt        = 8'd0;
                    space_pend_nxt = (inputSignal == SYM_SPACE);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A pending word space always wins; any SPACE in the same cycle collapses into it.
    assign push_req  = space_pend || fsm_push;
    assign push_char = space_pend ? 8'h20 : fsm_char;
    assign push_err  = !space_pend && fsm_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len        <= 4'd0;
            pat        <= 8'd0;
            space_pend <= 1'b0;
            last_char  <= 8'h20;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            len        <= len_nxt;
            pat        <= pat_nxt;
            space_pend <= space_pend_nxt;
            err        <= push_req && push_err;
            if (push_req) last_char <= push_char;
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && out_ready;
    assign wr_en      = push_req && (!fifo_full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (push_req && !wr_en) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_char;
    end

    assign out_valid = !fifo_empty;
    assign out_char  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/morse_char_decoder.md
# morse_char_decoder

Parametrised successor to the single-letter alphabet FSM. It accumulates Morse elements (DIT/DAH) into a variable-length pattern and decodes the full ITU set: letters, digits and, when enabled, punctuation. Decoded ASCII characters, including word spaces, go into an internal FIFO with a valid/ready output handshake. It sits between the element classifier (which produces the 3-bit symbol code) and the character sink (display or UART).

## Interface
- MAX_ELEMS, default 6: maximum elements per character. Legal range 5..8. When below 6, the punctuation entries are disabled.
- FIFO_DEPTH, default 4: output FIFO depth in characters. Must be a power of two, 2..16.
- clk  in  1  rising-edge clock; the only clock in the block.
- rst_n  in  1  reset, asynchronous assert, active-low.
- inputSignal  in  3  symbol code, sampled every clk edge: 0 WAIT, 1 DIT, 2 DAH, 3 GAP (end of character), 4 SPACE (end of word). Codes 5..7 are treated as WAIT.
- out_ready  in  1  sink accepts the FIFO head this cycle.
- out_valid  out  1  FIFO non-empty.
- out_char  out  8  ASCII at the FIFO head. Value is 0x00 when empty.
- err  out  1  one-cycle pulse when an unmapped or overrun pattern is pushed.
- overflow  out  1  sticky; set when a push is dropped because the FIFO is full. Cleared only by reset.

## Operation
- Pattern register: shift left, DIT shifts in 0, DAH shifts in 1. Length counter runs 0..MAX_ELEMS. Example: B (-...) is len 4, pat 4'b1000.
- FSM states:
  - IDLE (len 0)
    - DIT/DAH: go to COLLECT.
    - GAP: no effect.
    - SPACE: push 0x20, unless the last pushed char was 0x20 (repeated spaces collapse).
  - COLLECT
    - DIT/DAH: shift in the element.
    - If DIT/DAH arrives with len == MAX_ELEMS: go to OVERRUN.
    - GAP: decode and push, then go to IDLE.
    - SPACE: decode and push, set space_pending, go to IDLE.
  - OVERRUN: elements are ignored.
    - GAP: push 0x2A ('*'), pulse err, go to IDLE.
    - SPACE: push 0x2A ('*'), pulse err, set space_pending, go to IDLE.
- space_pending: pushes 0x20 on the next cycle and has priority over any push from that cycle's input. A SPACE in that cycle collapses into it. A GAP in that cycle pushes nothing (len is 0). DIT/DAH in that cycle are still collected.
- Decode table:
  - A–Z map to 0x41–0x5A.
  - 0–9 are 5-element patterns, mapping to 0x30–0x39.
  - With MAX_ELEMS ≥ 6: .-.-.- maps to 0x2E, --..-- to 0x2C, ..--.. to 0x3F.
  - Any other (len, pat) pushes 0x2A and pulses err.
- FIFO:
  - Write and read pointers are log2(FIFO_DEPTH)+1 bits; full/empty are determined from the MSB.
  - A push while full is dropped and sets overflow. The FSM still advances.
  - Push and pop in the same cycle while full: the pop frees a slot and the push is accepted.
  - Push and pop in the same cycle while empty: no bypass; only the push takes effect.
- Reset (any time, including mid-character or mid-pending-space):
  - FSM to IDLE; len, pat, space_pending cleared.
  - FIFO emptied; the last-pushed tracker is set to 0x20, so a leading SPACE is suppressed.
  - Outputs after reset: out_valid 0, out_char 0x00, err 0, overflow 0.

## Timing
- The GAP or SPACE sampled at edge N pushes at edge N. out_valid is high after edge N, provided the FIFO was not full.
- space_pending's 0x20 is pushed at edge N+1.
- err is high for exactly the cycle following the push edge.
- Pop happens at an edge where out_valid && out_ready. out_char is valid whenever out_valid is high, and changes only at a pop or at the first push into an empty FIFO.
- out_valid, out_char and err are all registered or driven directly from storage; there is no combinational path from inputSignal to any output.

## Test plan
- Hold out_ready=1 and send DIT, GAP, WAIT, WAIT -> one char 0x45; out_valid high for 1 cycle after the GAP edge; err stays 0.
- Send DAH, DIT, DIT, DIT, GAP -> 0x42. Then send DIT×5, GAP -> 0x35. Then send .-.-.-, GAP -> 0x2E. Repeat the last one with MAX_ELEMS=5 -> 0x2A plus an err pulse.
- Send DIT, SPACE, SPACE, SPACE -> exactly 0x45 then 0x20 (spaces collapse). Send SPACE right after reset -> nothing pushed.
- Set MAX_ELEMS=6 and send DIT×8, GAP -> one 0x2A, err pulses for 1 cycle, FSM back to IDLE; a following DIT, GAP gives 0x45.
- Hold out_ready=0 and decode 6 letters with FIFO_DEPTH=4 -> first 4 retained in order and overflow=1. Then raise out_ready -> the 4 chars drain one per cycle and overflow stays 1.
- Send DAH, DIT and pulse rst_n low for half a cycle -> outputs go to reset values immediately. A following DIT, GAP gives 0x45, not a stale pattern.
